vc_ctrl_param: RTL and testbench
================================

// Module: vc_ctrl_param
// PURPOSE
//  Parametrised per-input-VC controller for the NoC router: RC -> VSA -> ST packet flow.
//  One instance per (input physical channel, VC). Drives switch requests, output-VC lock and per-flit send.
//  Generalised over port/VC count. Adds flit-level valid/ready send, packet-length watchdog and error flag.
// PARAMETERS
//  NPORT      5   number of router output ports
//  NVCH       2   VCs per port
//  PCHID      0   input physical channel id (informational)
//  VCHID      0   input VC id (informational)
//  MAXLEN     16  max flits per packet incl. head; >=2
//  AGE_LIMIT  8   VSA cycles before priority request (VC_AGE_EN only); >=1
//  Derived: PW=max(1,$clog2(NPORT)), VW=max(1,$clog2(NVCH)), CW=$clog2(MAXLEN+1)
// PORTS
//  clk       in   1            clock
//  rst_      in   1            sync reset, active-low (one clock; reset is synchronous and active-low)
//  bdata     in   `DATAW+1     head-of-buffer flit; type = bdata[`TYPE_MSB:`TYPE_LSB]
//  bvalid    in   1            bdata valid (buffer non-empty)
//  send      out  1            flit dequeued and sent this cycle
//  olck      out  1            this VC holds an output VC (state != RC)
//  irdy      in   NPORT*NVCH   downstream VC can take a flit; bit p*NVCH+v
//  ilck      in   NPORT*NVCH   downstream VC locked by another input; same indexing
//  grt       in   NPORT        switch grant per output port
//  req       out  1            switch request
//  req_pri   out  1            aged/priority request (0 unless VC_AGE_EN)
//  port      in   PW           routed output port (from RC logic)
//  ovch      in   VW           allocated output VC
//  flit_cnt  out  CW           flits sent in current packet
//  err       out  1            sticky error: bad port or over-length packet
// BEHAVIOUR
//  Reset (rst_==0 at posedge): state=RC, req=0, req_pri=0, flit_cnt=0, err=0, age=0; send=0.
//  Select: g=grt[port], r=irdy[port*NVCH+ovch], l=ilck[port*NVCH+ovch]; all read 0 if port>=NPORT or ovch>=NVCH.
//  olck = (state!=RC), combinational.
//  send = (state==ST) && bvalid && g && r, combinational; no send in RC/VSA.
//  RC: if bvalid && type in {HEAD,HEADTAIL}:
//   port<NPORT && ovch<NVCH -> VSA, req<=1 (req visible cycle after head valid).
//   else -> stay RC, err<=1, req stays 0. Non-head flits in RC ignored.
//  VSA (priority order, one action per cycle):
//   g && r -> ST, req<=1, flit_cnt<=0.
//   else l -> req<=0 (stay VSA).
//   else   -> req<=1 (stay VSA).
//  ST: req held 1. On each send: flit_cnt<=flit_cnt+1.
//   send && type in {TAIL,HEADTAIL} -> RC, req<=0, flit_cnt<=0.
//   send && !tail && flit_cnt==MAXLEN-1 -> RC, req<=0, err<=1 (watchdog; rest of packet dropped by upstream).
//   !send (bvalid=0, g=0 or r=0) -> stay ST, flit_cnt holds.
//  Min latency head-valid -> first send: 2 cycles (RC->VSA, VSA->ST) then send in ST.
//  flit_cnt never exceeds MAXLEN; no wrap.
//  err cleared only by reset. Reset mid-packet aborts immediately to RC, all state cleared.
// CONFIGURATION
//  VC_AGE_EN defined: AW-bit age counter in VSA; +1 per VSA cycle with req=1 and !(g&&r), saturating at AGE_LIMIT.
//   req_pri<=1 when age reaches AGE_LIMIT; age and req_pri cleared on leaving VSA and on reset.
//   req_pri stays 1 while VSA && l (req=0).
//  VC_AGE_EN undefined: no counter; req_pri tied 0. All other behaviour identical.
// TESTING
//  HEADTAIL, bvalid=1, port=2, ovch=1, grt[2]=1, irdy[5]=1 -> req=1 @c1, ST @c2, send=1 @c2, RC @c3, flit_cnt 0.
//  HEAD+2 BODY+TAIL, irdy drops 2 cycles mid-packet -> send=0 during gap, flit_cnt 0..3, olck=1 throughout, 4 sends total.
//  VSA with ilck[port*NVCH+ovch]=1, grt=0 for 3 cycles -> req=0, stays VSA. ilck then 0 -> req=1 next cycle.
//  MAXLEN=4, HEAD+5 BODY, no tail -> after 4th send state=RC, err=1, req=0; err persists until rst_=0.
//  HEAD with port=7 (NPORT=5) -> state RC, err=1, req=0, olck=0.
//  VC_AGE_EN, AGE_LIMIT=3, grt=0 -> req_pri=1 after 3 VSA cycles. grt&&irdy -> ST, req_pri=0. rst_=0 in ST -> all outputs 0 next cycle.

Source files
------------

// File: rtl/vc_ctrl_param.sv
// ============================================================================
//  Module   : vc_ctrl_param
//  Purpose  : Per-input-VC controller (RC -> VSA -> ST) with flit-level send,
//             packet-length watchdog and sticky error flag.
//  Option   : define VC_AGE_EN to enable the VSA age counter / priority request.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATAW
`define DATAW 31
`endif
`ifndef TYPE_MSB
`define TYPE_MSB `DATAW
`endif
`ifndef TYPE_LSB
`define TYPE_LSB (`DATAW-2)
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'b000
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 3'b001
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'b010
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 3'b011
`endif

module vc_ctrl_param #(
    parameter int NPORT     = 5,
    parameter int NVCH      = 2,
    parameter int PCHID     = 0,
    parameter int VCHID     = 0,
    parameter int MAXLEN    = 16,
    parameter int AGE_LIMIT = 8,
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1,
    localparam int VW = (NVCH > 1) ? $clog2(NVCH) : 1,
    localparam int CW = $clog2(MAXLEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [`DATAW:0]       bdata,
    input  logic                  bvalid,
    output logic                  send,
    output logic                  olck,
    input  logic [NPORT*NVCH-1:0] irdy,
    input  logic [NPORT*NVCH-1:0] ilck,
    input  logic [NPORT-1:0]      grt,
    output logic                  req,
    output logic                  req_pri,
    input  logic [PW-1:0]         port,
    input  logic [VW-1:0]         ovch,
    output logic [CW-1:0]         flit_cnt,
    output logic                  err
);

    generate
        if (MAXLEN < 2 || AGE_LIMIT < 1 || PCHID < 0 || VCHID < 0) begin : g_bad_param
            $error("vc_ctrl_param: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RC  = 2'd0,
        ST_VSA = 2'd1,
        ST_ST  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(MAXLEN - 1);

    state_t        state;
    state_t        state_d;
    logic          req_d;
    logic          err_d;
    logic [CW-1:0] flit_cnt_d;

    logic [2:0]    ftype;
    logic          is_head;
    logic          is_tail;
    logic          sel_ok;
    logic          g;
    logic          r;
    logic          l;
    logic          unused_bdata;

    assign ftype        = bdata[`TYPE_MSB:`TYPE_LSB];
    assign is_head      = (ftype == `TYPE_HEAD) || (ftype == `TYPE_HEADTAIL);
    assign is_tail      = (ftype == `TYPE_TAIL) || (ftype == `TYPE_HEADTAIL);
    assign unused_bdata = ^bdata;

    // Out-of-range port/ovch values never match a loop index, so they read as 0.
    always_comb begin
        sel_ok = 1'b0;
        g      = 1'b0;
        r      = 1'b0;
        l      = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            for (int v = 0; v < NVCH; v++) begin
                if (port == PW'(p) && ovch == VW'(v)) begin
                    sel_ok = 1'b1;
                    g      = grt[p];
                    r      = irdy[p*NVCH + v];
                    l      = ilck[p*NVCH + v];
                end
            end
        end
    end

    assign olck = (state != ST_RC);
    assign send = (state == ST_ST) && bvalid && g && r;

    always_comb begin
        state_d    = state;
        req_d      = req;
        err_d      = err;
        flit_cnt_d = flit_cnt;
        case (state)
            ST_RC: begin
                if (bvalid && is_head) begin
                    if (sel_ok) begin
                        state_d = ST_VSA;
                        req_d   = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ST_VSA: begin
                if (g && r) begin
                    state_d    = ST_ST;
                    req_d      = 1'b1;
                    flit_cnt_d = '0;
                end else if (l) begin
                    req_d      = 1'b0;
                end else begin
                    req_d      = 1'b1;
                end
            end
            ST_ST: begin
                req_d = 1'b1;
                if (send) begin
                    flit_cnt_d = flit_cnt + 1'b1;
                    if (is_tail) begin
                        state_d    = ST_RC;
                        req_d      = 1'b0;
                        flit_cnt_d = '0;
                    end else if (flit_cnt == CNT_LAST) begin
                        // Over-length packet: release the output VC and flag it.
                        state_d = ST_RC;
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RC;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state    <= ST_RC;
            req      <= 1'b0;
            err      <= 1'b0;
            flit_cnt <= '0;
        end else begin
            state    <= state_d;
            req      <= req_d;
            err      <= err_d;
            flit_cnt <= flit_cnt_d;
        end
    end

`ifdef VC_AGE_EN
    localparam int            AW      = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    logic [AW-1:0] age;
    logic [AW-1:0] age_d;
    logic          req_pri_q;
    logic          req_pri_d;

    // Age only accumulates while waiting in VSA; any exit clears it.
    always_comb begin
        age_d     = '0;
        req_pri_d = 1'b0;
        if (state == ST_VSA && state_d == ST_VSA) begin
            age_d = age;
            if (req && !(g && r) && age != AGE_MAX) begin
                age_d = age + 1'b1;
            end
            req_pri_d = req_pri_q || (age_d == AGE_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            age       <= '0;
            req_pri_q <= 1'b0;
        end else begin
            age       <= age_d;
            req_pri_q <= req_pri_d;
        end
    end

    assign req_pri = req_pri_q;
`else
    assign req_pri = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc_ctrl_param.sv
// ============================================================================
//  Module   : tb_vc_ctrl_param
//  Purpose  : Self-checking bench for vc_ctrl_param (vector table + sequences).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATAW
`define DATAW 31
`endif
`ifndef TYPE_MSB
`define TYPE_MSB `DATAW
`endif
`ifndef TYPE_LSB
`define TYPE_LSB (`DATAW-2)
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'b000
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 3'b001
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'b010
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 3'b011
`endif

module tb_vc_ctrl_param;

    localparam int NPORT     = 5;
    localparam int NVCH      = 2;
    localparam int MAXLEN    = 4;
    localparam int AGE_LIMIT = 3;
    localparam int PW        = 3;
    localparam int VW        = 1;
    localparam int CW        = 3;

    logic                  clk;
    logic                  rst_;
    logic [`DATAW:0]       bdata;
    logic                  bvalid;
    logic                  send;
    logic                  olck;
    logic [NPORT*NVCH-1:0] irdy;
    logic [NPORT*NVCH-1:0] ilck;
    logic [NPORT-1:0]      grt;
    logic                  req;
    logic                  req_pri;
    logic [PW-1:0]         port;
    logic [VW-1:0]         ovch;
    logic [CW-1:0]         flit_cnt;
    logic                  err;

    vc_ctrl_param #(
        .NPORT     (NPORT),
        .NVCH      (NVCH),
        .PCHID     (0),
        .VCHID     (0),
        .MAXLEN    (MAXLEN),
        .AGE_LIMIT (AGE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .bdata    (bdata),
        .bvalid   (bvalid),
        .send     (send),
        .olck     (olck),
        .irdy     (irdy),
        .ilck     (ilck),
        .grt      (grt),
        .req      (req),
        .req_pri  (req_pri),
        .port     (port),
        .ovch     (ovch),
        .flit_cnt (flit_cnt),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int port;
        int ovch;
        int nflits;
        int tail;
        int decoy;
        int exp_sends;
        int exp_err;
        int exp_olck;
        int exp_req;
        int exp_cnt;
    } vec_t;

    vec_t            tbl[8];
    logic [`DATAW:0] fq[$];
    int              exp_q[$];
    int              nsend;
    int              checks;
    int              errors;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_buf();
        bvalid = (fq.size() != 0);
        bdata  = bvalid ? fq[0] : '0;
    endtask

    // One clock: sample send mid-cycle, score it, advance, dequeue the sent flit.
    task automatic tick();
        bit fired;
        fired = 1'b0;
        #2;
        if (send === 1'b1) begin
            fired = 1'b1;
            nsend++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_send: got send=1 expected no send (t=%0t)", $time);
            end else begin
                check("send_flit_cnt", int'(flit_cnt), exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (fired && fq.size() != 0) fq.delete(0);
        drive_buf();
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        fq.delete();
        exp_q.delete();
        grt  = '0;
        irdy = '0;
        ilck = '0;
        port = '0;
        ovch = '0;
        drive_buf();
        tick();
        rst_ = 1'b1;
        check("rst_olck", int'(olck), 0);
        check("rst_req", int'(req), 0);
        check("rst_req_pri", int'(req_pri), 0);
        check("rst_flit_cnt", int'(flit_cnt), 0);
        check("rst_err", int'(err), 0);
        check("rst_send", int'(send), 0);
        nsend = 0;
    endtask

    task automatic load_pkt(input int nflits, input int tail);
        logic [`DATAW:0] f;
        logic [2:0]      t;
        for (int i = 0; i < nflits; i++) begin
            if (nflits == 1 && tail != 0)      t = `TYPE_HEADTAIL;
            else if (i == 0)                   t = `TYPE_HEAD;
            else if (i == nflits-1 && tail != 0) t = `TYPE_TAIL;
            else                               t = `TYPE_BODY;
            f = '0;
            f[`TYPE_MSB:`TYPE_LSB] = t;
            f[7:0] = 8'(i + 1);
            fq.push_back(f);
        end
        drive_buf();
        #1;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(i);
    endtask

    task automatic route(input int p, input int v, input int decoy);
        port = PW'(p);
        ovch = VW'(v);
        if (p >= NPORT) begin
            grt  = '1;
            irdy = '1;
        end else if (decoy != 0) begin
            grt  = ~(NPORT'(1) << p);
            irdy = (NPORT*NVCH)'(1) << (p*NVCH + (1 - v));
        end else begin
            grt  = NPORT'(1) << p;
            irdy = (NPORT*NVCH)'(1) << (p*NVCH + v);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        nsend  = 0;
        rst_   = 1'b0;
        grt    = '0;
        irdy   = '0;
        ilck   = '0;
        port   = '0;
        ovch   = '0;
        drive_buf();
        @(posedge clk);
        #1;

        // port ovch nflits tail decoy | sends err olck req cnt
        tbl[0] = '{2, 1, 1, 1, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 3, 1, 0, 3, 0, 0, 0, 0};
        tbl[2] = '{4, 1, 4, 1, 0, 4, 0, 0, 0, 0};
        tbl[3] = '{3, 0, 6, 0, 0, 4, 1, 0, 0, 4};
        tbl[4] = '{7, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[5] = '{5, 1, 2, 1, 0, 0, 1, 0, 0, 0};
        tbl[6] = '{2, 1, 2, 1, 1, 0, 0, 1, 1, 0};
        tbl[7] = '{1, 1, 2, 1, 0, 2, 0, 0, 0, 0};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            route(tbl[i].port, tbl[i].ovch, tbl[i].decoy);
            load_pkt(tbl[i].nflits, tbl[i].tail);
            push_exp(tbl[i].exp_sends);
            repeat (20) tick();
            check($sformatf("v%0d_sends", i), nsend, tbl[i].exp_sends);
            check($sformatf("v%0d_err", i), int'(err), tbl[i].exp_err);
            check($sformatf("v%0d_olck", i), int'(olck), tbl[i].exp_olck);
            check($sformatf("v%0d_req", i), int'(req), tbl[i].exp_req);
            check($sformatf("v%0d_flit_cnt", i), int'(flit_cnt), tbl[i].exp_cnt);
            check($sformatf("v%0d_req_pri", i), int'(req_pri), 0);
        end

        // Minimum latency: head at c0, req at c1, send at c2, back in RC at c3.
        do_reset();
        route(2, 1, 0);
        load_pkt(1, 1);
        push_exp(1);
        check("lat_c0_req", int'(req), 0);
        check("lat_c0_send", int'(send), 0);
        tick();
        check("lat_c1_req", int'(req), 1);
        check("lat_c1_olck", int'(olck), 1);
        check("lat_c1_send", int'(send), 0);
        tick();
        check("lat_c2_send", int'(send), 1);
        check("lat_c2_olck", int'(olck), 1);
        tick();
        check("lat_c3_olck", int'(olck), 0);
        check("lat_c3_req", int'(req), 0);
        check("lat_c3_flit_cnt", int'(flit_cnt), 0);
        check("lat_sends", nsend, 1);

        // Downstream stalls for two cycles in the middle of a packet.
        do_reset();
        route(1, 0, 0);
        load_pkt(4, 1);
        push_exp(4);
        for (int k = 0; k < 12; k++) begin
            irdy[2] = !(k == 3 || k == 4);
            #1;
            if (k >= 1 && k <= 7) check($sformatf("gap_olck_k%0d", k), int'(olck), 1);
            if (k == 3 || k == 4) check($sformatf("gap_send_k%0d", k), int'(send), 0);
            if (k == 4) check("gap_flit_cnt", int'(flit_cnt), 1);
            tick();
        end
        check("gap_sends", nsend, 4);
        check("gap_end_olck", int'(olck), 0);
        check("gap_end_err", int'(err), 0);

        // Target VC locked by another input: request withdrawn until unlock.
        do_reset();
        port    = 3'd1;
        ovch    = 1'b0;
        ilck[2] = 1'b1;
        load_pkt(2, 1);
        push_exp(2);
        tick();
        check("lck_c1_req", int'(req), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lck_req_%0d", k), int'(req), 0);
            check($sformatf("lck_olck_%0d", k), int'(olck), 1);
        end
        ilck[2] = 1'b0;
        tick();
        check("lck_release_req", int'(req), 1);
        grt[1]  = 1'b1;
        irdy[2] = 1'b1;
        repeat (6) tick();
        check("lck_sends", nsend, 2);
        check("lck_end_olck", int'(olck), 0);

        // Reset asserted while in ST aborts the packet.
        do_reset();
        route(2, 1, 0);
        load_pkt(3, 1);
        push_exp(1);
        repeat (3) tick();
        irdy = '0;
        tick();
        check("abort_pre_olck", int'(olck), 1);
        check("abort_pre_flit_cnt", int'(flit_cnt), 1);
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        irdy[5] = 1'b1;
        #1;
        check("abort_olck", int'(olck), 0);
        check("abort_req", int'(req), 0);
        check("abort_flit_cnt", int'(flit_cnt), 0);
        check("abort_err", int'(err), 0);
        check("abort_send", int'(send), 0);
        check("abort_req_pri", int'(req_pri), 0);

`ifdef VC_AGE_EN
        // Waiting in VSA without grant raises the priority request.
        do_reset();
        route(0, 0, 0);
        grt = '0;
        load_pkt(2, 1);
        push_exp(2);
        repeat (3) tick();
        check("age_c3_req_pri", int'(req_pri), 0);
        tick();
        check("age_c4_req_pri", int'(req_pri), 1);
        grt[0] = 1'b1;
        tick();
        check("age_st_olck", int'(olck), 1);
        check("age_st_req_pri", int'(req_pri), 0);
        repeat (4) tick();
        check("age_sends", nsend, 2);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
